// File: rtl/rb_on_g_pipe.sv
// rb_on_g_pipe: 3-stage red/blue-at-green interpolator with valid/ready backpressure and clamping.
// Optional saturation statistics are enabled by defining RB_ON_G_PIPE_STATS_EN.
module rb_on_g_pipe #(
  parameter int PIXEL_BW = 12,
  parameter int GRAD_BW  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PIXEL_BW-1:0]   green,
  input  logic [4*PIXEL_BW-1:0] g_nbr,
  input  logic [4*PIXEL_BW-1:0] r_nbr,
  input  logic [4*PIXEL_BW-1:0] b_nbr,
  input  logic [GRAD_BW-1:0]    alpha_h,
  input  logic [1:0]            mode,
  input  logic                  sof_in,
  input  logic                  eol_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PIXEL_BW-1:0]   red,
  output logic [PIXEL_BW-1:0]   blue,
  output logic                  sof_out,
  output logic                  eol_out
`ifdef RB_ON_G_PIPE_STATS_EN
  ,
  output logic [15:0]           sat_count
`endif
);
  localparam int DW = PIXEL_BW + 2;
  localparam int WW = GRAD_BW + 1;
  localparam int AW = PIXEL_BW + GRAD_BW + 4;
  localparam logic [WW-1:0]        W_FULL = {1'b1, {GRAD_BW{1'b0}}};
  localparam logic [WW-1:0]        W_HALF = {2'b01, {(GRAD_BW-1){1'b0}}};
  localparam logic signed [AW-1:0] RND    = {{(AW-WW){1'b0}}, W_FULL};
  localparam logic signed [AW-1:0] PMAX   = {{(AW-PIXEL_BW){1'b0}}, {PIXEL_BW{1'b1}}};

  // Neighbour index: 0 v_m1, 1 h_m1, 2 h_p1, 3 v_p1.
  function automatic logic [PIXEL_BW-1:0] nbr(input logic [4*PIXEL_BW-1:0] bus, input int idx);
    return bus[idx*PIXEL_BW +: PIXEL_BW];
  endfunction

  function automatic logic signed [DW-1:0] cdiff(input logic [4*PIXEL_BW-1:0] x,
                                                 input logic [4*PIXEL_BW-1:0] g,
                                                 input int lo, input int hi);
    return ({2'b00, nbr(x, lo)} - {2'b00, nbr(g, lo)}) + ({2'b00, nbr(x, hi)} - {2'b00, nbr(g, hi)});
  endfunction

  function automatic logic signed [AW-1:0] sext(input logic signed [DW-1:0] d);
    return {{(AW-DW){d[DW-1]}}, d};
  endfunction

  function automatic logic signed [AW-1:0] zext_w(input logic [WW-1:0] w);
    return {{(AW-WW){1'b0}}, w};
  endfunction

  function automatic logic is_clamped(input logic signed [AW-1:0] s);
    return s[AW-1] || (s > PMAX);
  endfunction

  function automatic logic [PIXEL_BW-1:0] clamp_pix(input logic signed [AW-1:0] s);
    logic [PIXEL_BW-1:0] v;
    if (s[AW-1])        v = {PIXEL_BW{1'b0}};
    else if (s > PMAX)  v = {PIXEL_BW{1'b1}};
    else                v = s[PIXEL_BW-1:0];
    return v;
  endfunction

  logic                       w_en;
  logic [WW-1:0]              w_wh, w_wv;
  logic signed [AW-1:0]       w_acc_r, w_acc_b;
  logic signed [AW-1:0]       w_rnd_r, w_rnd_b, w_sum_r, w_sum_b;

  logic                       r_s1_valid, r_s1_sof, r_s1_eol;
  logic signed [DW-1:0]       r_s1_dh_r, r_s1_dv_r, r_s1_dh_b, r_s1_dv_b;
  logic [WW-1:0]              r_s1_wh, r_s1_wv;
  logic [PIXEL_BW-1:0]        r_s1_green;

  logic                       r_s2_valid, r_s2_sof, r_s2_eol;
  logic signed [AW-1:0]       r_s2_acc_r, r_s2_acc_b;
  logic [PIXEL_BW-1:0]        r_s2_green;

  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  always_comb begin
    w_wh = W_HALF;
    w_wv = W_HALF;
    case (mode)
      2'd0: begin
        w_wh = {1'b0, alpha_h};
        w_wv = W_FULL - {1'b0, alpha_h};
      end
      2'd1: begin
        w_wh = W_FULL;
        w_wv = {WW{1'b0}};
      end
      2'd2: begin
        w_wh = {WW{1'b0}};
        w_wv = W_FULL;
      end
      2'd3: begin
        w_wh = W_HALF;
        w_wv = W_HALF;
      end
      default: begin
        w_wh = W_HALF;
        w_wv = W_HALF;
      end
    endcase
  end

  // Products fit in AW bits because wh + wv never exceeds full scale.
  assign w_acc_r = sext(r_s1_dh_r) * zext_w(r_s1_wh) + sext(r_s1_dv_r) * zext_w(r_s1_wv);
  assign w_acc_b = sext(r_s1_dh_b) * zext_w(r_s1_wh) + sext(r_s1_dv_b) * zext_w(r_s1_wv);

  assign w_rnd_r = (r_s2_acc_r + RND) >>> (GRAD_BW + 1);
  assign w_rnd_b = (r_s2_acc_b + RND) >>> (GRAD_BW + 1);
  assign w_sum_r = $signed({{(AW-PIXEL_BW){1'b0}}, r_s2_green}) + w_rnd_r;
  assign w_sum_b = $signed({{(AW-PIXEL_BW){1'b0}}, r_s2_green}) + w_rnd_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sof   <= 1'b0;
      r_s1_eol   <= 1'b0;
      r_s1_dh_r  <= '0;
      r_s1_dv_r  <= '0;
      r_s1_dh_b  <= '0;
      r_s1_dv_b  <= '0;
      r_s1_wh    <= '0;
      r_s1_wv    <= '0;
      r_s1_green <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_sof   <= sof_in;
      r_s1_eol   <= eol_in;
      r_s1_dh_r  <= cdiff(r_nbr, g_nbr, 1, 2);
      r_s1_dv_r  <= cdiff(r_nbr, g_nbr, 0, 3);
      r_s1_dh_b  <= cdiff(b_nbr, g_nbr, 1, 2);
      r_s1_dv_b  <= cdiff(b_nbr, g_nbr, 0, 3);
      r_s1_wh    <= w_wh;
      r_s1_wv    <= w_wv;
      r_s1_green <= green;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_sof   <= 1'b0;
      r_s2_eol   <= 1'b0;
      r_s2_acc_r <= '0;
      r_s2_acc_b <= '0;
      r_s2_green <= '0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_sof   <= r_s1_sof;
      r_s2_eol   <= r_s1_eol;
      r_s2_acc_r <= w_acc_r;
      r_s2_acc_b <= w_acc_b;
      r_s2_green <= r_s1_green;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sof_out   <= 1'b0;
      eol_out   <= 1'b0;
      red       <= '0;
      blue      <= '0;
    end else if (w_en) begin
      out_valid <= r_s2_valid;
      sof_out   <= r_s2_sof;
      eol_out   <= r_s2_eol;
      red       <= clamp_pix(w_sum_r);
      blue      <= clamp_pix(w_sum_b);
    end
  end

`ifdef RB_ON_G_PIPE_STATS_EN
  logic r_out_clamp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_out_clamp <= 1'b0;
    else if (w_en) r_out_clamp <= is_clamped(w_sum_r) || is_clamped(w_sum_b);
  end

  // A frame start restarts the count with that beat's own clamp status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= 16'd0;
    end else if (out_valid && out_ready) begin
      if (sof_out)                                  sat_count <= {15'd0, r_out_clamp};
      else if (r_out_clamp && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
    end
  end
`else
  // Saturation statistics compiled out.
`endif

endmodule

// File: tb/tb_rb_on_g_pipe.sv
// Directed bench for rb_on_g_pipe: vector table through a scoreboard plus latency,
// backpressure, mid-stream reset and (when enabled) saturation-counter sequences.
module tb_rb_on_g_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [11:0] green, red, blue;
  logic [47:0] g_nbr, r_nbr, b_nbr;
  logic [7:0]  alpha_h;
  logic [1:0]  mode;
  logic        sof_in, eol_in, sof_out, eol_out;
`ifdef RB_ON_G_PIPE_STATS_EN
  logic [15:0] sat_count;
`endif

  always #5 clk = ~clk;

  rb_on_g_pipe #(.PIXEL_BW(12), .GRAD_BW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .green(green), .g_nbr(g_nbr), .r_nbr(r_nbr), .b_nbr(b_nbr),
    .alpha_h(alpha_h), .mode(mode), .sof_in(sof_in), .eol_in(eol_in),
    .out_valid(out_valid), .out_ready(out_ready), .red(red), .blue(blue),
    .sof_out(sof_out), .eol_out(eol_out)
`ifdef RB_ON_G_PIPE_STATS_EN
    , .sat_count(sat_count)
`endif
  );

  typedef struct packed {
    logic [1:0]  mode;
    logic [7:0]  alpha;
    logic [11:0] green;
    logic [47:0] g;
    logic [47:0] r;
    logic [47:0] b;
    logic [11:0] er;
    logic [11:0] eb;
  } vec_t;

  typedef struct packed {
    logic [11:0] red;
    logic [11:0] blue;
    logic        sof;
    logic        eol;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [47:0] nb(input logic [11:0] h, input logic [11:0] v);
    return {v, h, h, v};
  endfunction

  function automatic vec_t mkv(input logic [1:0] m, input logic [7:0] a, input logic [11:0] gr,
                               input logic [47:0] g, input logic [47:0] r, input logic [47:0] b,
                               input logic [11:0] er, input logic [11:0] eb);
    vec_t v;
    v.mode = m; v.alpha = a; v.green = gr; v.g = g; v.r = r; v.b = b; v.er = er; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input vec_t v, input logic vld, input logic sof, input logic eol);
    in_valid = vld; mode = v.mode; alpha_h = v.alpha; green = v.green;
    g_nbr = v.g; r_nbr = v.r; b_nbr = v.b; sof_in = sof; eol_in = eol;
  endtask

  // One clock: drive at negedge, sample 1 ns later, score any delivered beat, queue any accepted one.
  task automatic run_cycle(input vec_t v, input logic vld, input logic sof, input logic eol,
                           input logic ordy, output logic acc, output logic rdy, output logic ov,
                           output logic [11:0] rr, output logic [11:0] bb);
    exp_t e;
    drive(v, vld, sof, eol);
    out_ready = ordy;
    #1;
    rdy = in_ready; ov = out_valid; rr = red; bb = blue;
    acc = vld && in_ready;
    if (out_valid && out_ready) begin
      chk("beat_expected", {31'd0, q.size() != 0}, 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("red", red, e.red);
        chk("blue", blue, e.blue);
        chk("sof_out", sof_out, e.sof);
        chk("eol_out", eol_out, e.eol);
      end
    end
    if (acc) begin
      e.red = v.er; e.blue = v.eb; e.sof = sof; e.eol = eol;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  vec_t idle_v;
  task automatic drain();
    logic a, r, o;
    logic [11:0] x, y;
    for (int i = 0; i < 20 && q.size() != 0; i++) run_cycle(idle_v, 1'b0, 1'b0, 1'b0, 1'b1, a, r, o, x, y);
    chk("drain_empty", q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t        tbl[10];
  vec_t        bv;
  logic        acc, rdy, ov;
  logic [11:0] rr, bb, st_r, st_b;
  int          bi, cyc, nv;

  initial begin
    idle_v = mkv(2'd0, 8'd0, 12'd0, 48'd0, 48'd0, 48'd0, 12'd0, 12'd0);
    tbl[0] = mkv(2'd0, 8'd128, 12'd1000, nb(12'd1000, 12'd1000), nb(12'd1200, 12'd1200), nb(12'd800, 12'd800), 12'd1200, 12'd800);
    tbl[1] = mkv(2'd1, 8'd0, 12'd1000, nb(12'd1000, 12'd1000), nb(12'd1100, 12'd1500), nb(12'd1000, 12'd1000), 12'd1100, 12'd1000);
    tbl[2] = mkv(2'd2, 8'd0, 12'd1000, nb(12'd1000, 12'd1000), nb(12'd1100, 12'd1500), nb(12'd1000, 12'd1000), 12'd1500, 12'd1000);
    tbl[3] = mkv(2'd3, 8'd0, 12'd1000, nb(12'd1000, 12'd1000), nb(12'd1100, 12'd1500), nb(12'd1000, 12'd1000), 12'd1300, 12'd1000);
    tbl[4] = mkv(2'd3, 8'd0, 12'd4000, nb(12'd0, 12'd0), nb(12'd4095, 12'd4095), nb(12'd0, 12'd0), 12'd4095, 12'd4000);
    tbl[5] = mkv(2'd0, 8'd37, 12'd100, nb(12'd4095, 12'd4095), nb(12'd4095, 12'd4095), nb(12'd0, 12'd0), 12'd100, 12'd0);
    tbl[6] = mkv(2'd0, 8'd64, 12'd2000, nb(12'd2000, 12'd2000), nb(12'd2010, 12'd2002), nb(12'd1990, 12'd1998), 12'd2004, 12'd1996);
    tbl[7] = mkv(2'd1, 8'd0, 12'd500, nb(12'd500, 12'd500), {12'd500, 12'd500, 12'd501, 12'd500},
                 {12'd500, 12'd500, 12'd499, 12'd500}, 12'd501, 12'd500);
    tbl[8] = mkv(2'd0, 8'd0, 12'd300, nb(12'd300, 12'd300), nb(12'd100, 12'd400), nb(12'd300, 12'd300), 12'd400, 12'd300);
    tbl[9] = mkv(2'd0, 8'd255, 12'd300, nb(12'd300, 12'd300), nb(12'd400, 12'd100), nb(12'd300, 12'd300), 12'd399, 12'd300);

    // Power-on reset
    rst = 1'b1;
    out_ready = 1'b1;
    drive(idle_v, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_red", red, 32'd0);
    chk("rst_blue", blue, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 32'd1);
    @(negedge clk);

    // Single-beat latency: valid must appear on the third edge after accept
    drive(tbl[0], 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive(idle_v, 1'b0, 1'b0, 1'b0);
    chk("lat_edge1", out_valid, 32'd0);
    @(negedge clk);
    chk("lat_edge2", out_valid, 32'd0);
    @(negedge clk);
    chk("lat_edge3", out_valid, 32'd1);
    chk("lat_red", red, 32'd1200);
    chk("lat_blue", blue, 32'd800);
    chk("lat_sof", sof_out, 32'd1);
    @(negedge clk);
    chk("lat_single", out_valid, 32'd0);

    // Back-to-back table vectors through the scoreboard
    for (int i = 0; i < 10; i++) run_cycle(tbl[i], 1'b1, i == 2, i == 5, 1'b1, acc, rdy, ov, rr, bb);
    drain();

    // Backpressure: 8 beats, 4-cycle stall once the pipe is full
    bi = 0;
    cyc = 0;
    while (bi < 8 && cyc < 40) begin
      bv = mkv(2'd3, 8'd0, 12'(1000 + 37 * bi), nb(12'(1000 + 37 * bi), 12'(1000 + 37 * bi)),
               nb(12'(1005 + 37 * bi), 12'(1005 + 37 * bi)), nb(12'(995 + 37 * bi), 12'(995 + 37 * bi)),
               12'(1005 + 37 * bi), 12'(995 + 37 * bi));
      run_cycle(bv, 1'b1, bi == 0, bi == 7, !(cyc >= 5 && cyc < 9), acc, rdy, ov, rr, bb);
      if (cyc >= 5 && cyc < 9) begin
        chk("stall_in_ready", rdy, 32'd0);
        chk("stall_out_valid", ov, 32'd1);
        if (cyc == 5) begin
          st_r = rr;
          st_b = bb;
        end else begin
          chk("stall_red_stable", rr, st_r);
          chk("stall_blue_stable", bb, st_b);
        end
      end
      if (acc) bi++;
      cyc++;
    end
    chk("bp_all_accepted", bi, 32'd8);
    drain();

    // Mid-stream reset with beats in flight
    for (int i = 0; i < 3; i++) run_cycle(tbl[0], 1'b1, 1'b0, 1'b0, 1'b1, acc, rdy, ov, rr, bb);
    rst = 1'b1;
    #1;
    chk("mrst_out_valid", out_valid, 32'd0);
    chk("mrst_red", red, 32'd0);
    chk("mrst_blue", blue, 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      run_cycle(idle_v, 1'b0, 1'b0, 1'b0, 1'b1, acc, rdy, ov, rr, bb);
      if (ov) nv++;
      if (i == 0) chk("mrst_in_ready", rdy, 32'd1);
    end
    chk("mrst_no_stale", nv, 32'd0);

`ifdef RB_ON_G_PIPE_STATS_EN
    chk("sat_after_rst", sat_count, 32'd0);
    for (int i = 0; i < 3; i++) run_cycle(tbl[4], 1'b1, 1'b0, 1'b0, 1'b1, acc, rdy, ov, rr, bb);
    drain();
    chk("sat_three", sat_count, 32'd3);
    run_cycle(tbl[0], 1'b1, 1'b1, 1'b0, 1'b1, acc, rdy, ov, rr, bb);
    drain();
    chk("sat_sof_clear", sat_count, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rb_on_g_pipe.md
Name: rb_on_g_pipe

Overview:
Parametrised, pipelined successor to the red/blue-at-green-site interpolator in the CFA demosaic datapath. At each green Bayer site it estimates the missing red and blue values. It uses colour-difference averaging along the horizontal and vertical axes, mixed by a per-pixel directional weight and a selectable interpolation mode. It adds a valid/ready stream handshake with backpressure, sideband pass-through, fixed 3-cycle latency and output clamping. It sits between the green-interpolation stage and the output packer.

Parameters:
PIXEL_BW, 12, pixel bit width for all colour samples.
GRAD_BW, 8, directional weight width; weight full scale is 2^GRAD_BW.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  input beat valid.
in_ready  out  1  block accepts a beat when in_valid && in_ready.
green  in  PIXEL_BW  centre green sample.
g_nbr  in  4*PIXEL_BW  green at neighbours, packed {v_p1,h_p1,h_m1,v_m1} (v_m1 in LSBs).
r_nbr  in  4*PIXEL_BW  red estimates at the same neighbours, same packing.
b_nbr  in  4*PIXEL_BW  blue estimates at the same neighbours, same packing.
alpha_h  in  GRAD_BW  horizontal weight, 0..2^GRAD_BW-1.
mode  in  2  0 adaptive, 1 horizontal-only, 2 vertical-only, 3 plain average.
sof_in, eol_in  in  1 each  start-of-frame / end-of-line sideband.
out_valid  out  1  output beat valid.
out_ready  in  1  downstream accept.
red, blue  out  PIXEL_BW each  interpolated outputs.
sof_out, eol_out  out  1 each  sideband aligned with red/blue.

Behaviour:
- Reset, asynchronous and active-high: all stage valids 0; out_valid=0; red=blue=0; sof_out=eol_out=0; in_ready=1 once rst deasserts.
- Global advance: en = !out_valid || out_ready; in_ready = en (combinational). When en=0, every pipeline register holds its value. red, blue and the sideband outputs stay stable while out_valid && !out_ready.
- Latency: exactly 3 en-cycles from input accept to out_valid. Throughput is 1 beat/cycle when out_ready=1. Bubbles propagate as valid=0 and are not collapsed.
- Stage 1, per colour X in {r,b}, computed signed over PIXEL_BW+2 bits:
  - dh_X = (X.h_m1 - g.h_m1) + (X.h_p1 - g.h_p1)
  - dv_X = (X.v_m1 - g.v_m1) + (X.v_p1 - g.v_p1)
- Stage 1 weights, GRAD_BW+1 bits unsigned, selected per beat by mode:
  - mode 0: wh = alpha_h, wv = 2^GRAD_BW - alpha_h
  - mode 1: wh = 2^GRAD_BW, wv = 0
  - mode 2: wh = 0, wv = 2^GRAD_BW
  - mode 3: wh = wv = 2^(GRAD_BW-1)
- Stage 1 also registers green, sof_in and eol_in.
- Stage 2: acc_X = dh_X*wh + dv_X*wv, signed, full precision. Width is PIXEL_BW+GRAD_BW+4 bits, so no overflow is possible.
- Stage 3: corr_X = (acc_X + 2^GRAD_BW) >>> (GRAD_BW+1), an arithmetic shift with round-half-up. sum_X = green + corr_X, signed.
- Stage 3 clamp: sum_X < 0 gives 0; sum_X > 2^PIXEL_BW-1 gives 2^PIXEL_BW-1; otherwise sum_X. Red and blue are registered outputs.
- mode and alpha_h are sampled per beat with the data; changing them between beats affects only later beats.
- Sideband bits travel unmodified through all 3 stages.
- Reset mid-stream: all in-flight beats are discarded and no partial output is produced.

Optional Feature:
RB_ON_G_PIPE_STATS_EN
- Defined: adds sat_count output, 16 bits. It increments once per accepted output beat (out_valid && out_ready) in which red or blue was clamped. It saturates at 0xFFFF, clears on rst, and clears synchronously on an accepted beat with sof_out=1 (that beat's own clamp is then counted from 0).
- Not defined: sat_count port and logic are absent. All other behaviour is identical.

Test Plan:
- Reset check, defaults: assert rst mid-stream with 2 beats in flight -> immediately out_valid=0, red=blue=0; after release, in_ready=1 and no stale beat emerges.
- Mode 0, alpha_h=128, green=1000, all g_nbr=1000, all r_nbr=1200, all b_nbr=800 -> red=1200, blue=800 on the 3rd cycle after accept.
- Mode 1, green=1000, g_nbr=1000, r h-neighbours=1100, r v-neighbours=1500 -> red=1100. Same data in mode 2 -> red=1500; in mode 3 -> red=1300.
- Clamp: green=4000, g_nbr=0, r_nbr=4095 -> red=4095. Then green=100, g_nbr=4095, b_nbr=0 -> blue=0.
- Backpressure: stream 8 beats with distinct greens and sof on beat 0, eol on beat 7; hold out_ready=0 for 4 cycles mid-stream -> in_ready=0 during the stall, outputs stable, all 8 beats emerge in order with sideband aligned.
- With RB_ON_G_PIPE_STATS_EN: 3 clamping beats then a non-clamping sof beat -> sat_count=3, then 0 after the sof beat is accepted.
